// File: rtl/ddr_frame_writer_if.sv
// AXI write-address/write-data bundle between ddr_frame_writer and the ddr3_32 IP.
interface ddr_frame_writer_if;
  logic [27:0]  axi_awaddr;
  logic         axi_awuser_ap;
  logic [3:0]   axi_awuser_id;
  logic [3:0]   axi_awlen;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wready;
  logic         axi_wusero_last;

  modport master (
    output axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    output axi_wdata, axi_wstrb,
    input  axi_awready, axi_wready, axi_wusero_last
  );

  modport slave (
    input  axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    input  axi_wdata, axi_wstrb,
    output axi_awready, axi_wready, axi_wusero_last
  );
endinterface

// File: rtl/ddr_frame_writer.sv
// RGB565 -> 256-bit beat packer, beat FIFO and fixed-length AXI burst writer with frame double-buffering.
// Optional FRAME_WR_DROP_CNT_EN adds o_drop_cnt, a saturating count of beats dropped on FIFO overflow.
module ddr_frame_writer #(
  parameter logic [27:0] BASE_ADDR0  = 28'h0000000,
  parameter logic [27:0] BASE_ADDR1  = 28'h0100000,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned ADDR_STRIDE = 8,
  parameter int unsigned FRAME_BEATS = 57600,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter logic [3:0]  AXI_ID      = 4'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                i_vsync,
  input  logic                i_valid,
  input  logic [15:0]         i_data,
  ddr_frame_writer_if.master  axi,
  output logic                o_buf_sel,
  output logic                o_frame_done,
  output logic                o_overflow
`ifdef FRAME_WR_DROP_CNT_EN
  ,
  output logic [15:0]         o_drop_cnt
`endif
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [27:0] BURST_BYTES = 28'(BURST_LEN * ADDR_STRIDE);
  localparam logic [27:0] FRAME_BYTES = 28'(FRAME_BEATS * ADDR_STRIDE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]   state;
  logic         vsync_d, vs_rise, pending;
  logic [3:0]   pix_cnt;
  logic [239:0] pack_buf;
  logic         beat_rdy;
  logic [255:0] beat_data;

  logic [255:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic         wr_buf;
  logic [27:0]  offset;
  logic [27:0]  awaddr_q;
  logic [27:0]  offset_next;
  logic [3:0]   beat_cnt;

  logic pix_accept, full, push, pop, drop, flush;

  assign flush       = (state == IDLE) && pending;
  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign push        = beat_rdy && !full && !flush;
  assign drop        = beat_rdy && full && !flush;
  assign pop         = (state == DATA) && axi.axi_wready;
  assign pix_accept  = i_valid && !pending && !vs_rise;
  assign offset_next = (offset + BURST_BYTES >= FRAME_BYTES) ? '0 : offset + BURST_BYTES;

  assign axi.axi_awaddr    = awaddr_q;
  assign axi.axi_awvalid   = (state == ADDR);
  assign axi.axi_awuser_ap = 1'b0;
  assign axi.axi_awuser_id = AXI_ID;
  assign axi.axi_awlen     = 4'(BURST_LEN - 1);
  assign axi.axi_wstrb     = '1;
  assign axi.axi_wdata     = (count == '0) ? '0 : mem[rd_ptr];

  // Pixel packer; a vsync edge restarts the beat so a partial beat never reaches the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      vs_rise   <= 1'b0;
      pix_cnt   <= '0;
      pack_buf  <= '0;
      beat_rdy  <= 1'b0;
      beat_data <= '0;
    end else begin
      vsync_d  <= i_vsync;
      vs_rise  <= i_vsync & ~vsync_d;
      beat_rdy <= 1'b0;
      if (vs_rise) begin
        pix_cnt <= '0;
      end else if (pix_accept) begin
        if (pix_cnt == 4'd15) begin
          beat_data <= {i_data, pack_buf};
          beat_rdy  <= 1'b1;
          pix_cnt   <= '0;
        end else begin
          pack_buf[16*pix_cnt +: 16] <= i_data;
          pix_cnt <= pix_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= beat_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) o_overflow <= 1'b1;
    end
  end

`ifdef FRAME_WR_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_drop_cnt <= '0;
    end else if (flush) begin
      o_drop_cnt <= '0;
    end else if (drop && o_drop_cnt != '1) begin
      o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

  // Frame switches are only taken from IDLE, so a burst already on the bus always finishes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      awaddr_q     <= BASE_ADDR0;
      offset       <= '0;
      wr_buf       <= 1'b0;
      pending      <= 1'b0;
      o_buf_sel    <= 1'b0;
      o_frame_done <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (vs_rise) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending) begin
            o_buf_sel    <= wr_buf;
            wr_buf       <= ~wr_buf;
            offset       <= '0;
            o_frame_done <= 1'b1;
            pending      <= 1'b0;
          end else if (en && count >= (AW+1)'(BURST_LEN)) begin
            state    <= ADDR;
            awaddr_q <= (wr_buf ? BASE_ADDR1 : BASE_ADDR0) + offset;
          end
        end
        ADDR: begin
          if (axi.axi_awready) begin
            state    <= DATA;
            beat_cnt <= '0;
            offset   <= offset_next;
          end
        end
        DATA: begin
          if (pop) begin
            if (beat_cnt == 4'(BURST_LEN - 1)) state <= IDLE;
            else beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(axi.axi_wusero_last && state != DATA));
  end
`endif

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Scoreboard bench: runs a default-size writer and a 16-beat-frame writer side by side on one stimulus.
`timescale 1ns/1ps
module tb_ddr_frame_writer;

  localparam int unsigned BURST   = 8;
  localparam logic [27:0] BASE0   = 28'h0000000;
  localparam logic [27:0] BASE1   = 28'h0100000;
  localparam logic [27:0] BBYTES  = 28'd64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, vsync = 1'b0, valid = 1'b0;
  logic [15:0] data = '0;
  logic awready = 1'b1, wready = 1'b1;

  logic [1:0]   buf_sel, frame_done, overflow, awvalid_a, ap_a;
  logic [27:0]  awaddr_a [2];
  logic [255:0] wdata_a [2];
  logic [3:0]   awlen_a [2];
  logic [3:0]   id_a [2];
  logic [31:0]  wstrb_a [2];
`ifdef FRAME_WR_DROP_CNT_EN
  logic [15:0]  drop_a [2];
`endif

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      ddr_frame_writer_if bus ();
      assign bus.axi_awready     = awready;
      assign bus.axi_wready      = wready;
      assign bus.axi_wusero_last = 1'b0;
      assign awvalid_a[g] = bus.axi_awvalid;
      assign awaddr_a[g]  = bus.axi_awaddr;
      assign wdata_a[g]   = bus.axi_wdata;
      assign awlen_a[g]   = bus.axi_awlen;
      assign id_a[g]      = bus.axi_awuser_id;
      assign ap_a[g]      = bus.axi_awuser_ap;
      assign wstrb_a[g]   = bus.axi_wstrb;

      ddr_frame_writer #(.FRAME_BEATS(g == 0 ? 57600 : 16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i_vsync      (vsync),
        .i_valid      (valid),
        .i_data       (data),
        .axi          (bus),
        .o_buf_sel    (buf_sel[g]),
        .o_frame_done (frame_done[g]),
        .o_overflow   (overflow[g])
`ifdef FRAME_WR_DROP_CNT_EN
        ,
        .o_drop_cnt   (drop_a[g])
`endif
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and transaction-level model
  logic [255:0] exp_data_q [2][$];
  logic [27:0]  exp_addr_q [2][$];
  logic [255:0] mq [$];
  logic [255:0] m_beat = '0;
  int           m_k = 0;
  logic [27:0]  m_off [2];
  logic [27:0]  frame_bytes [2];
  logic         m_buf = 1'b0;
  logic         m_en = 1'b0;
  int           m_drops = 0;
  logic [15:0]  pix = '0;

  int wleft [2];
  int w_total [2];
  int fd_cnt [2];

  task automatic model_issue();
    logic [255:0] d;
    while (m_en && mq.size() >= BURST) begin
      for (int i = 0; i < 2; i++) begin
        exp_addr_q[i].push_back((m_buf ? BASE1 : BASE0) + m_off[i]);
        m_off[i] = (m_off[i] + BBYTES >= frame_bytes[i]) ? 28'd0 : m_off[i] + BBYTES;
      end
      for (int b = 0; b < BURST; b++) begin
        d = mq.pop_front();
        exp_data_q[0].push_back(d);
        exp_data_q[1].push_back(d);
      end
    end
  endtask

  task automatic model_pixel(input logic [15:0] px);
    m_beat[16*m_k +: 16] = px;
    m_k++;
    if (m_k == 16) begin
      m_k = 0;
      if (mq.size() == 32) m_drops++;
      else mq.push_back(m_beat);
      model_issue();
    end
  endtask

  task automatic model_switch();
    mq.delete();
    m_k = 0;
    m_buf = ~m_buf;
    m_off[0] = '0;
    m_off[1] = '0;
    m_drops = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      data  = pix;
      model_pixel(pix);
      pix++;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_addr_q[0].size() + exp_addr_q[1].size() +
            exp_data_q[0].size() + exp_data_q[1].size()) != 0 && t < 2000) begin
      cycles(1);
      t++;
    end
    cycles(5);
    check("drain_left", 256'(exp_addr_q[0].size() + exp_addr_q[1].size() +
                             exp_data_q[0].size() + exp_data_q[1].size()), 256'd0);
  endtask

  task automatic wait_switch(input logic exp_sel);
    int base = fd_cnt[0];
    int t = 0;
    while (fd_cnt[0] == base && t < 200) begin
      cycles(1);
      t++;
    end
    cycles(20);
    check("frame_done_pulses", 256'(fd_cnt[0] - base), 256'd1);
    check("buf_sel0", 256'(buf_sel[0]), 256'(exp_sel));
    check("buf_sel1", 256'(buf_sel[1]), 256'(exp_sel));
  endtask

  // Monitor: sampled on the falling edge; wready only pulls beats during a burst.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (wleft[i] > 0 && wready) begin
          if (exp_data_q[i].size() == 0) check($sformatf("w_unexpected%0d", i), 256'd1, 256'd0);
          else check($sformatf("wdata%0d", i), wdata_a[i], exp_data_q[i].pop_front());
          wleft[i]--;
          w_total[i]++;
        end
        if (awvalid_a[i] && awready) begin
          if (exp_addr_q[i].size() == 0) check($sformatf("aw_unexpected%0d", i), 256'd1, 256'd0);
          else check($sformatf("awaddr%0d", i), 256'(awaddr_a[i]), 256'(exp_addr_q[i].pop_front()));
          check($sformatf("awlen%0d", i), 256'(awlen_a[i]), 256'd7);
          wleft[i] += BURST;
        end
        if (frame_done[i]) fd_cnt[i]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, fdbase, t;
    frame_bytes[0] = 28'd460800;
    frame_bytes[1] = 28'd128;
    for (int i = 0; i < 2; i++) begin
      m_off[i] = '0; wleft[i] = 0; w_total[i] = 0; fd_cnt[i] = 0;
    end

    cycles(3);
    for (int i = 0; i < 2; i++) begin
      check("rst_awvalid", 256'(awvalid_a[i]), 256'd0);
      check("rst_awaddr", 256'(awaddr_a[i]), 256'(BASE0));
      check("rst_wdata", wdata_a[i], 256'd0);
      check("rst_buf_sel", 256'(buf_sel[i]), 256'd0);
      check("rst_frame_done", 256'(frame_done[i]), 256'd0);
      check("rst_overflow", 256'(overflow[i]), 256'd0);
      check("awlen_const", 256'(awlen_a[i]), 256'd7);
      check("wstrb_const", 256'(wstrb_a[i]), 256'hFFFF_FFFF);
      check("awid_const", 256'(id_a[i]), 256'd0);
      check("awap_const", 256'(ap_a[i]), 256'd0);
`ifdef FRAME_WR_DROP_CNT_EN
      check("rst_drop_cnt", 256'(drop_a[i]), 256'd0);
`endif
    end
    rst = 1'b0;
    cycles(2);

    // Two plain bursts
    en = 1'b1; m_en = 1'b1;
    send_pixels(256);
    wait_drain();

    // Address channel stall
    awready = 1'b0;
    send_pixels(128);
    t = 0;
    while (!awvalid_a[0] && t < 50) begin cycles(1); t++; end
    for (int c = 0; c < 20; c++) begin
      cycles(1);
      check("hold_awvalid", 256'(awvalid_a[0]), 256'd1);
      check("hold_awaddr0", 256'(awaddr_a[0]), 256'(exp_addr_q[0][0]));
      check("hold_awaddr1", 256'(awaddr_a[1]), 256'(exp_addr_q[1][0]));
    end
    awready = 1'b1;
    wait_drain();

    // Frame switch with 100 pixels buffered
    send_pixels(100);
    cycles(5);
    vsync = 1'b1;
    model_switch();
    wait_switch(1'b0);
    vsync = 1'b0;
    send_pixels(128);
    wait_drain();

    // Frame switch (two edges) while a burst is stalled after 3 beats
    base = w_total[0];
    fdbase = fd_cnt[0];
    send_pixels(128);
    t = 0;
    while (w_total[0] < base + 3 && t < 100) begin cycles(1); t++; end
    wready = 1'b0;
    vsync = 1'b1; valid = 1'b1; data = 16'hDEAD;
    model_switch();
    cycles(1); vsync = 1'b0;
    cycles(1); vsync = 1'b1;
    cycles(1); valid = 1'b0;
    cycles(10);
    check("beats_before_stall", 256'(w_total[0] - base), 256'd3);
    check("no_switch_mid_burst", 256'(fd_cnt[0] - fdbase), 256'd0);
    wready = 1'b1;
    wait_switch(1'b1);
    check("beats_after_stall", 256'(w_total[0] - base), 256'd8);
    vsync = 1'b0;
    send_pixels(128);
    wait_drain();

    // Overflow with en low, then drain
    check("overflow_pre", 256'(overflow[0]), 256'd0);
    en = 1'b0; m_en = 1'b0;
    send_pixels(640);
    cycles(5);
    check("overflow0", 256'(overflow[0]), 256'd1);
    check("overflow1", 256'(overflow[1]), 256'd1);
    check("model_drops", 256'(m_drops), 256'd8);
`ifdef FRAME_WR_DROP_CNT_EN
    check("drop_cnt0", 256'(drop_a[0]), 256'd8);
    check("drop_cnt1", 256'(drop_a[1]), 256'd8);
`endif
    en = 1'b1; m_en = 1'b1;
    model_issue();
    wait_drain();

    // New frame, 24 beats: small-frame instance wraps after two bursts
    vsync = 1'b1;
    model_switch();
    wait_switch(1'b0);
`ifdef FRAME_WR_DROP_CNT_EN
    check("drop_cnt_cleared", 256'(drop_a[0]), 256'd0);
`endif
    check("overflow_sticky", 256'(overflow[0]), 256'd1);
    vsync = 1'b0;
    send_pixels(384);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_frame_writer.md
Name: ddr_frame_writer

Overview:
Write-side DDR3 frame-buffer stage: consumes the RGB565 pixel stream from the camera reader path (already moved into the DDR PHY clock domain) and writes it to DDR3 through the ddr3_32 AXI write channels. Packs 16 pixels per 256-bit beat, buffers the beats, and issues fixed-length bursts. Double-buffers frames between two base addresses and reports which buffer was completed last, for the read/display side.

Parameters:
BASE_ADDR0, 28'h0000000, frame buffer 0 base address
BASE_ADDR1, 28'h0100000, frame buffer 1 base address
BURST_LEN, 8, beats per AXI burst (1..16); axi_awlen = BURST_LEN-1
ADDR_STRIDE, 8, address increment per 256-bit beat
FRAME_BEATS, 57600, beats per frame (1280x720/16); multiple of BURST_LEN
FIFO_DEPTH, 32, beat FIFO depth, power of 2, >= 2*BURST_LEN
AXI_ID, 4'h0, value driven on axi_awuser_id

Ports:
clk  input  1  DDR PHY user clock (phy_clk)
rst  input  1  asynchronous active-high reset
en  input  1  DDR initialised; AW issue allowed only while high
i_vsync  input  1  frame sync, level; rising edge = frame boundary
i_valid  input  1  pixel strobe (no backpressure)
i_data  input  16  RGB565 pixel
axi_awaddr  output  28  burst address
axi_awuser_ap  output  1  constant 0
axi_awuser_id  output  4  constant AXI_ID
axi_awlen  output  4  constant BURST_LEN-1
axi_awvalid  output  1  address valid
axi_awready  input  1  address accepted
axi_wdata  output  256  write beat
axi_wstrb  output  32  constant 32'hFFFF_FFFF
axi_wready  input  1  IP pulls one beat per cycle high
axi_wusero_last  input  1  unused except assertion check
o_buf_sel  output  1  buffer index of last completed frame
o_frame_done  output  1  one-cycle pulse at frame switch
o_overflow  output  1  sticky: a beat was dropped

Behaviour:
- Reset: awvalid=0, awaddr=BASE_ADDR0, wdata=0, o_buf_sel=0, o_frame_done=0, o_overflow=0; FIFO empty, packer cleared, write buffer=0, offset=0, FSM IDLE.
- Packer: pixel k (0..15) placed at wdata bits [16k+15:16k]; the 16th pixel completes a beat, pushed to FIFO the next cycle.
- FIFO full at push: beat discarded, o_overflow set (cleared only by rst).
- FSM IDLE: if en && fifo_count>=BURST_LEN && no pending frame switch -> ADDR; awaddr = base(buffer) + offset.
- ADDR: awvalid=1, address stable until awready; on handshake -> DATA; offset += BURST_LEN*ADDR_STRIDE; when offset reaches FRAME_BEATS*ADDR_STRIDE it wraps to 0.
- DATA: show-ahead FIFO; axi_wdata = FIFO head; each cycle axi_wready=1 pops one beat. After BURST_LEN pops -> IDLE. FIFO guaranteed non-empty (>=BURST_LEN at issue). Push and pop in the same cycle keep count unchanged.
- Vsync rising edge (registered edge detect, 1-cycle latency): packer cleared immediately (partial beat dropped); switch pending set.
- Switch applied in IDLE (immediately if already IDLE, else after the current burst completes; in-flight bursts are never aborted): FIFO flushed, o_buf_sel = current buffer, buffer toggles, offset=0, o_frame_done pulses 1 cycle, pending cleared.
- Pixels arriving while switch pending are dropped (blanking region).
- Second vsync edge while pending: single switch.
- en low: no new AW; an in-flight burst completes; packing and FIFO continue (overflow possible).
- Assert (sim only): axi_wusero_last never high outside DATA.

Optional Feature:
FRAME_WR_DROP_CNT_EN: adds port o_drop_cnt output 16, saturating count of discarded beats (overflow drops only), cleared to 0 at each applied frame switch and by rst. Without the macro, the port is absent and only sticky o_overflow exists.

Test Plan:
- 128 pixels value=index, en=1, awready/wready always 1 -> one burst at awaddr=0x0000000, awlen=7, beat0 = {px15..px0}, 8 beats, then idle; second 128 pixels -> awaddr=0x0000040.
- Hold awready=0 for 20 cycles -> awvalid stays high, awaddr stable; release -> single handshake, no duplicate burst.
- vsync edge with 100 pixels buffered -> 100 pixels flushed, o_frame_done one pulse, o_buf_sel=0, next burst at BASE_ADDR1 (0x0100000).
- vsync edge mid-DATA (3 of 8 beats sent) -> remaining 5 beats sent, then switch; next burst at new base offset 0.
- en=0, stream 40 beats (FIFO_DEPTH=32) -> 8 beats dropped, o_overflow=1, o_drop_cnt=8 with macro; en=1 -> 4 bursts drain.
- FRAME_BEATS=16, BURST_LEN=8, stream 24 beats without vsync -> addresses 0x00, 0x40, then wraps to 0x00.
